// File: rtl/gmii_tx_arb_pkg.sv
// Shared types and defaults for the GMII transmit arbiter.
package gmii_tx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    SEND  = 2'd2,
    GAP   = 2'd3
  } arb_state_e;

  localparam int DEFAULT_IFG       = 12;
  localparam int DEFAULT_MAX_FRAME = 1526;

endpackage

// File: rtl/gmii_arb_rr.sv
// Two-way round-robin pick: the source that was not served last wins a tie.
module gmii_arb_rr
  import gmii_tx_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_served,
  output logic [1:0] winner
);

  always_comb begin
    winner = req;
    if (req == 2'b11) begin
      winner = last_served ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/gmii_tx_arbiter.sv
// GMII transmit arbiter: two frame sources share one GMII output with round-robin
// grants and an enforced inter-frame gap. Optional frame watchdog: GMII_TX_ARB_WATCHDOG_EN.
module gmii_tx_arbiter
  import gmii_tx_arb_pkg::*;
#(
  parameter int IFG_CYCLES = DEFAULT_IFG,
  parameter int MAX_FRAME  = DEFAULT_MAX_FRAME
) (
  input  logic       gmii_tx_clk,
  input  logic       rst_n,
  input  logic       src0_req,
  output logic       src0_grant,
  input  logic       src0_tx_en,
  input  logic [7:0] src0_txd,
  input  logic       src1_req,
  output logic       src1_grant,
  input  logic       src1_tx_en,
  input  logic [7:0] src1_txd,
  output logic       gmii_tx_en,
  output logic [7:0] gmii_txd,
  output logic       arb_err
);

  localparam int               GAP_W    = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(IFG_CYCLES - 1);

  arb_state_e       state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic             last_q, last_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             out_en_q, out_en_d;
  logic [7:0]       out_txd_q, out_txd_d;
  logic [1:0]       winner;
  logic             sel_req;
  logic             sel_en;
  logic [7:0]       sel_txd;

`ifdef GMII_TX_ARB_WATCHDOG_EN
  localparam int                BYTE_W   = $clog2(MAX_FRAME + 1);
  localparam logic [BYTE_W-1:0] BYTE_MAX = BYTE_W'(MAX_FRAME);

  logic [BYTE_W-1:0] byte_q, byte_d;
  logic              trunc_q, trunc_d;
  logic              err_q, err_d;
`else
  logic [31:0] unused_max_frame;
  assign unused_max_frame = 32'(MAX_FRAME);
  assign arb_err          = 1'b0;
`endif

  gmii_arb_rr u_rr (
    .req         ({src1_req, src0_req}),
    .last_served (last_q),
    .winner      (winner)
  );

  // AND-OR select keeps the ungranted source fully isolated from the output path.
  assign sel_req = (grant_q[0] & src0_req) | (grant_q[1] & src1_req);
  assign sel_en  = (grant_q[0] & src0_tx_en) | (grant_q[1] & src1_tx_en);
  assign sel_txd = ({8{grant_q[0]}} & src0_txd) | ({8{grant_q[1]}} & src1_txd);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    gap_d     = gap_q;
    out_en_d  = 1'b0;
    out_txd_d = 8'h00;
`ifdef GMII_TX_ARB_WATCHDOG_EN
    byte_d    = byte_q;
    trunc_d   = trunc_q;
    err_d     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (|winner) begin
          grant_d = winner;
          state_d = GRANT;
        end
      end
      GRANT: begin
        out_en_d  = sel_en;
        out_txd_d = sel_txd;
        if (sel_en) begin
          state_d = SEND;
`ifdef GMII_TX_ARB_WATCHDOG_EN
          byte_d  = BYTE_W'(1);
`endif
        end else if (!sel_req) begin
          grant_d = 2'b00;
          state_d = IDLE;
        end
      end
      SEND: begin
        out_en_d  = sel_en;
        out_txd_d = sel_txd;
        if (!sel_en) begin
          grant_d = 2'b00;
          last_d  = grant_q[1];
          gap_d   = GAP_LOAD;
          state_d = GAP;
`ifdef GMII_TX_ARB_WATCHDOG_EN
          byte_d  = '0;
          trunc_d = 1'b0;
`endif
        end
`ifdef GMII_TX_ARB_WATCHDOG_EN
        // Past the limit the source keeps its grant but its bytes are swallowed.
        else if (byte_q < BYTE_MAX) begin
          byte_d = byte_q + BYTE_W'(1);
        end else begin
          out_en_d  = 1'b0;
          out_txd_d = 8'h00;
          err_d     = !trunc_q;
          trunc_d   = 1'b1;
        end
`endif
      end
      GAP: begin
        if (gap_q == '0) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= 2'b00;
      last_q    <= 1'b1;
      gap_q     <= '0;
      out_en_q  <= 1'b0;
      out_txd_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      gap_q     <= gap_d;
      out_en_q  <= out_en_d;
      out_txd_q <= out_txd_d;
    end
  end

`ifdef GMII_TX_ARB_WATCHDOG_EN
  always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_q  <= '0;
      trunc_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      byte_q  <= byte_d;
      trunc_q <= trunc_d;
      err_q   <= err_d;
    end
  end

  assign arb_err = err_q;
`endif

  assign src0_grant = grant_q[0];
  assign src1_grant = grant_q[1];
  assign gmii_tx_en = out_en_q;
  assign gmii_txd   = out_txd_q;

endmodule

// File: tb/tb_gmii_tx_arbiter.sv
// Self-checking bench for gmii_tx_arbiter: cycle table, directed corner cases,
// and randomized frame traffic checked against a frame-level scoreboard.
module tb_gmii_tx_arbiter;

  localparam int IFG = 12;
`ifdef GMII_TX_ARB_WATCHDOG_EN
  localparam int MAXF = 100;
`else
  localparam int MAXF = 0;
`endif

  logic       gmii_tx_clk = 1'b0;
  logic       rst_n;
  logic       src0_req, src0_grant, src0_tx_en;
  logic [7:0] src0_txd;
  logic       src1_req, src1_grant, src1_tx_en;
  logic [7:0] src1_txd;
  logic       gmii_tx_en;
  logic [7:0] gmii_txd;
  logic       arb_err;

  int checks = 0;
  int errors = 0;

  gmii_tx_arbiter #(
    .IFG_CYCLES (IFG),
    .MAX_FRAME  ((MAXF == 0) ? 1526 : MAXF)
  ) dut (
    .gmii_tx_clk (gmii_tx_clk),
    .rst_n       (rst_n),
    .src0_req    (src0_req),
    .src0_grant  (src0_grant),
    .src0_tx_en  (src0_tx_en),
    .src0_txd    (src0_txd),
    .src1_req    (src1_req),
    .src1_grant  (src1_grant),
    .src1_tx_en  (src1_tx_en),
    .src1_txd    (src1_txd),
    .gmii_tx_en  (gmii_tx_en),
    .gmii_txd    (gmii_txd),
    .arb_err     (arb_err)
  );

  always #4 gmii_tx_clk = ~gmii_tx_clk;

  initial begin
    #700000;
    $display("[TB] FAIL global_timeout: simulation did not end, required finish");
    $fatal(1, "[TB] timeout");
  end

  // Scoreboard / source-agent state
  int         flen[2][$];
  logic [7:0] fbytes[2][$];
  bit         sending[2];
  int         remain[2];
  int         idx[2];
  logic [7:0] expq[$];
  int         grant_log[$];
  bit         last_served;
  logic [1:0] prev_req, prev_g;
  int         idle_run, nbytes_out, err_seen, err_exp;
  bit         in_frame;

  typedef struct {
    logic r0, e0; logic [7:0] d0;
    logic r1, e1; logic [7:0] d1;
    logic [1:0] g; logic en; logic [7:0] d;
  } vec_t;
  vec_t tbl[22];

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r0, input logic e0, input logic [7:0] d0,
                               input logic r1, input logic e1, input logic [7:0] d1);
    src0_req = r0; src0_tx_en = e0; src0_txd = d0;
    src1_req = r1; src1_tx_en = e1; src1_txd = d1;
  endtask

  task automatic tick();
    @(posedge gmii_tx_clk); #1;
  endtask

  task automatic row(input int i, input logic r0, input logic e0, input logic [7:0] d0,
                     input logic r1, input logic e1, input logic [7:0] d1,
                     input logic [1:0] g, input logic en, input logic [7:0] d);
    tbl[i] = '{r0, e0, d0, r1, e1, d1, g, en, d};
  endtask

  task automatic clearAgents();
    for (int s = 0; s < 2; s++) begin
      flen[s].delete(); fbytes[s].delete();
      sending[s] = 0; remain[s] = 0; idx[s] = 0;
    end
    expq.delete(); grant_log.delete();
    last_served = 1'b1; prev_req = 2'b00; prev_g = 2'b00;
    idle_run = 1000; nbytes_out = 0; err_seen = 0; err_exp = 0; in_frame = 0;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(0, 0, 8'h00, 0, 0, 8'h00);
    clearAgents();
    repeat (3) tick();
    checkOutput("rst_grant", {src1_grant, src0_grant}, 0);
    checkOutput("rst_tx_en", gmii_tx_en, 0);
    checkOutput("rst_txd", gmii_txd, 0);
    checkOutput("rst_arb_err", arb_err, 0);
    @(negedge gmii_tx_clk);
    rst_n = 1'b1;
  endtask

  task automatic queueFrame(input int s, input int len, input bit ramp);
    flen[s].push_back(len);
    for (int i = 0; i < len; i++) fbytes[s].push_back(ramp ? 8'(i) : 8'($urandom));
    if (MAXF != 0 && len > MAXF) err_exp++;
  endtask

  // One clock of the reference model: check what the DUT shows, then let each
  // source agent decide what it drives for the coming cycle.
  task automatic step();
    logic [1:0] g, r, e;
    logic [7:0] dd[2];
    int w;
    tick();
    g = {src1_grant, src0_grant};
    if (g != prev_g) checkOutput("grant_onehot", int'($countones(g) <= 1), 1);
    if (g != 2'b00 && prev_g == 2'b00) begin
      if (prev_req == 2'b11) w = last_served ? 0 : 1;
      else if (prev_req == 2'b10) w = 1;
      else if (prev_req == 2'b01) w = 0;
      else w = -1;
      checkOutput("rr_winner", g[1] ? 1 : 0, w);
      grant_log.push_back(g[1] ? 1 : 0);
    end
    if (arb_err) err_seen++;
    if (gmii_tx_en) begin
      if (!in_frame) checkOutput("ifg_idle_cycles", int'(idle_run >= IFG + 1), 1);
      if (expq.size() == 0) checkOutput("byte_without_frame", gmii_tx_en, 0);
      else checkOutput("gmii_txd_stream", gmii_txd, expq.pop_front());
      in_frame = 1; idle_run = 0; nbytes_out++;
    end else begin
      in_frame = 0; idle_run++;
    end

    for (int s = 0; s < 2; s++) begin
      r[s] = 0; e[s] = 0; dd[s] = 8'h00;
      if (!sending[s] && g[s] && flen[s].size() > 0) begin
        sending[s] = 1; remain[s] = flen[s].pop_front(); idx[s] = 0;
      end
      if (sending[s]) begin
        if (remain[s] > 0) begin
          r[s] = 1; e[s] = 1; dd[s] = fbytes[s].pop_front();
          if (MAXF == 0 || idx[s] < MAXF) expq.push_back(dd[s]);
          idx[s]++; remain[s]--;
        end else begin
          sending[s] = 0; last_served = (s == 1);
          r[s] = (flen[s].size() > 0);
        end
      end else begin
        r[s] = (flen[s].size() > 0);
        e[s] = 1'($urandom_range(0, 1));
        dd[s] = 8'($urandom);
      end
    end
    applyStimulus(r[0], e[0], dd[0], r[1], e[1], dd[1]);
    prev_g = g; prev_req = r;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (n < budget && (flen[0].size() + flen[1].size() + expq.size() != 0 ||
                          sending[0] || sending[1])) begin
      step(); n++;
    end
    checkOutput("drain_in_budget", int'(n < budget), 1);
    repeat (IFG + 4) step();
    checkOutput("arb_err_pulses", err_seen, err_exp);
  endtask

  initial begin
    int exp_order[3];
    int n;
    rst_n = 1'b0;
    applyStimulus(0, 0, 8'h00, 0, 0, 8'h00);

    // Withdrawal, isolation, gap length and tie-break after a served frame.
    row(0, 0, 0, 8'h00, 0, 0, 8'h00, 2'b00, 0, 8'h00);
    row(1, 0, 0, 8'h00, 1, 0, 8'h00, 2'b10, 0, 8'h00);
    row(2, 0, 0, 8'h00, 0, 0, 8'h00, 2'b00, 0, 8'h00);
    row(3, 1, 0, 8'h00, 0, 0, 8'h00, 2'b01, 0, 8'h00);
    row(4, 1, 1, 8'h11, 1, 1, 8'hAA, 2'b01, 1, 8'h11);
    row(5, 1, 1, 8'h22, 1, 1, 8'hAA, 2'b01, 1, 8'h22);
    for (int i = 6; i < 18; i++) row(i, 0, 0, 8'h00, 1, 1, 8'hAA, 2'b00, 0, 8'h00);
    row(18, 1, 0, 8'h00, 1, 1, 8'hAA, 2'b00, 0, 8'h00);
    row(19, 1, 0, 8'h00, 1, 0, 8'h00, 2'b10, 0, 8'h00);
    row(20, 1, 1, 8'hAA, 1, 1, 8'h5A, 2'b10, 1, 8'h5A);
    row(21, 0, 0, 8'h00, 0, 0, 8'h00, 2'b00, 0, 8'h00);

    doReset();
    for (int i = 0; i < 22; i++) begin
      applyStimulus(tbl[i].r0, tbl[i].e0, tbl[i].d0, tbl[i].r1, tbl[i].e1, tbl[i].d1);
      tick();
      checkOutput($sformatf("tbl_grant[%0d]", i), {src1_grant, src0_grant}, tbl[i].g);
      checkOutput($sformatf("tbl_tx_en[%0d]", i), gmii_tx_en, tbl[i].en);
      checkOutput($sformatf("tbl_txd[%0d]", i), gmii_txd, tbl[i].d);
    end

    // Single 64-byte ramp frame with src1 chattering 0xAA the whole time.
    doReset();
    applyStimulus(1, 0, 8'h00, 0, 1, 8'hAA);
    tick();
    checkOutput("single_grant_rise", {src1_grant, src0_grant}, 2'b01);
    for (int i = 0; i < 64; i++) begin
      applyStimulus(1, 1, 8'(i), 0, 1, 8'hAA);
      tick();
      checkOutput($sformatf("single_en[%0d]", i), gmii_tx_en, 1);
      checkOutput($sformatf("single_txd[%0d]", i), gmii_txd, i);
      checkOutput($sformatf("single_grant[%0d]", i), {src1_grant, src0_grant}, 2'b01);
    end
    applyStimulus(0, 0, 8'h00, 0, 1, 8'hAA);
    tick();
    checkOutput("single_grant_fall", {src1_grant, src0_grant}, 2'b00);
    checkOutput("single_en_fall", gmii_tx_en, 0);

    // Contention from reset: src0, src1, src0.
    doReset();
    queueFrame(0, 8, 0); queueFrame(0, 8, 0); queueFrame(1, 8, 0);
    drain(1000);
    exp_order = '{0, 1, 0};
    checkOutput("contention_grants", grant_log.size(), 3);
    for (int k = 0; k < 3; k++)
      checkOutput($sformatf("contention_order[%0d]", k),
                  (k < grant_log.size()) ? grant_log[k] : -1, exp_order[k]);

    // Randomized traffic.
    doReset();
    for (int rnd = 0; rnd < 6; rnd++) begin
      for (int s = 0; s < 2; s++) begin
        n = $urandom_range(0, 3);
        for (int f = 0; f < n; f++) queueFrame(s, $urandom_range(1, 40), 0);
      end
      drain(4000);
    end

    // Reset mid-frame at output byte 20.
    doReset();
    queueFrame(0, 60, 1);
    for (int c = 0; c < 200 && nbytes_out < 20; c++) step();
    checkOutput("midrst_reached_byte20", nbytes_out, 20);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_async_tx_en", gmii_tx_en, 0);
    checkOutput("midrst_async_grant", {src1_grant, src0_grant}, 2'b00);
    applyStimulus(0, 0, 8'h00, 0, 0, 8'h00);
    clearAgents();
    repeat (2) tick();
    @(negedge gmii_tx_clk);
    rst_n = 1'b1;
    queueFrame(1, 5, 0); queueFrame(0, 5, 0);
    drain(1000);
    checkOutput("midrst_grants", grant_log.size(), 2);
    checkOutput("midrst_first_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 0);

`ifdef GMII_TX_ARB_WATCHDOG_EN
    // Oversized frame is truncated to MAXF bytes, then traffic resumes.
    doReset();
    queueFrame(0, 150, 1); queueFrame(1, 10, 0);
    drain(2000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gmii_tx_arbiter.md
GMII_TX_ARBITER -- requirements
Module: gmii_tx_arbiter

Interface
REQ-001 Parameter IFG_CYCLES, default 12, SHALL set the idle gap inserted after every frame, in gmii_tx_clk cycles (minimum 1).
REQ-002 Parameter MAX_FRAME, default 1526, SHALL set the maximum tx_en-high length in bytes (preamble included), used only when the watchdog is compiled in.
REQ-003 The block SHALL use one clock, gmii_tx_clk; reset is rst_n, asynchronous, active-low.
REQ-004 Ports SHALL be:
- gmii_tx_clk  in  1  125 MHz GMII clock
- rst_n  in  1  async active-low reset
- src0_req  in  1  source 0 has a frame ready
- src0_grant  out  1  source 0 owns the output
- src0_tx_en  in  1  source 0 byte valid
- src0_txd  in  8  source 0 byte
- src1_req, src1_grant, src1_tx_en, src1_txd: same as source 0, for source 1
- gmii_tx_en  out  1  arbitrated GMII enable
- gmii_txd  out  8  arbitrated GMII data
- arb_err  out  1  one-cycle pulse on watchdog truncation

Function
REQ-005 The FSM SHALL have states IDLE, GRANT, SEND, GAP.
REQ-006 IDLE: if any srcN_req=1, the FSM SHALL pick a winner, assert srcN_grant on the next edge, and enter GRANT.
REQ-007 Arbitration SHALL be 2-way round-robin: the source not served last wins when both request; after reset, source 0 has priority.
REQ-008 GRANT: when the granted source's tx_en=1, the FSM SHALL enter SEND. If its req drops before tx_en rises, the FSM SHALL drop grant and return to IDLE with no gap, and last-served SHALL stay unchanged.
REQ-009 Output SHALL be registered with 1-cycle latency: gmii_tx_en/gmii_txd equal the granted source's tx_en/txd of the previous cycle while in GRANT or SEND, else 0/8'h00.
REQ-010 The ungranted source's tx_en/txd SHALL never reach the output.
REQ-011 SEND: on the first cycle granted tx_en=0, the FSM SHALL drop grant, record the served source as last-served, load the gap counter with IFG_CYCLES-1, and enter GAP.
REQ-012 GAP: the output SHALL be held 0, grants SHALL be 0, and requests SHALL be ignored. When the counter reaches 0, the FSM SHALL enter IDLE, so the next grant appears at the earliest IFG_CYCLES+1 cycles after the last data byte.
REQ-013 A request asserted in the same cycle that GAP→IDLE occurs SHALL be evaluated on the next cycle in IDLE, not lost.
REQ-014 srcN_grant SHALL be one-hot or zero at all times.

Reset
REQ-015 While rst_n=0: state=IDLE, grants=0, gmii_tx_en=0, gmii_txd=8'h00, arb_err=0, last-served=source 1 (so source 0 wins first), and the counters SHALL be 0.
REQ-016 Reset asserted mid-frame SHALL force the output low immediately (asynchronously); after release, no partial frame SHALL resume.

Configuration
REQ-017 Macro GMII_TX_ARB_WATCHDOG_EN defined: in SEND, a byte counter SHALL count tx_en-high cycles. On reaching MAX_FRAME, the block SHALL:
- force the output to 0,
- pulse arb_err for 1 cycle,
- keep grant asserted until the source's tx_en falls,
- then enter GAP as normal.
REQ-018 Macro GMII_TX_ARB_WATCHDOG_EN undefined: no byte counter SHALL exist, arb_err SHALL be tied 0, and frames of any length SHALL pass through.

Structure
REQ-019 Package gmii_tx_arb_pkg SHALL hold the FSM state typedef, the default IFG (12), and the default MAX_FRAME (1526).
REQ-020 Sub-module gmii_arb_rr SHALL implement the 2-way round-robin pick (inputs: req[1:0], last-served; output: one-hot winner).

Verification
REQ-021 Single frame: src0_req, then 64 bytes 0x00..0x3F -> gmii_txd reproduces them 1 cycle delayed; src0_grant falls the cycle after src0_tx_en falls.
REQ-022 Contention: both req held from reset -> order src0, src1, src0. Data-end to next tx_en is ≥13 cycles with IFG_CYCLES=12.
REQ-023 Isolation: src1 drives tx_en=1, txd=0xAA while src0 is granted -> 0xAA never appears on gmii_txd.
REQ-024 Withdrawal: src1_req pulses 1 cycle with no tx_en -> grant rises and falls, no GAP is inserted, and src0's subsequent request is granted immediately.
REQ-025 Watchdog (macro on, MAX_FRAME=100): 150-byte frame -> exactly 100 bytes output, a single arb_err pulse, then gap and normal operation.
REQ-026 Reset mid-frame at byte 20 -> gmii_tx_en=0 immediately; after release, the FSM is in IDLE and the first grant goes to src0.
